// File: rtl/stepper_pkg.sv
// Shared types and phase sequencing helpers for the stepper channel array.
package stepper_pkg;

  typedef enum logic [1:0] {IDLE, MOVE, HOLD} state_t;

  // Coil pattern per phase index, bit order {A1, B1, A2, B2}.
  localparam logic [3:0] PHASE_TABLE [8] = '{
    4'b1000, 4'b1100, 4'b0100, 4'b0110,
    4'b0010, 4'b0011, 4'b0001, 4'b1001
  };

  function automatic logic [2:0] phase_next(input logic [2:0] idx, input logic dir,
                                            input logic half);
    logic [2:0] stp;
    stp = half ? 3'd1 : 3'd2;
    return dir ? idx + stp : idx - stp;
  endfunction

endpackage

// File: rtl/stepper_array_ctrl_if.sv
// Digit/load command bus shared with the digit display source.
interface stepper_array_ctrl_if #(
  parameter int NUM_CH = 2,
  parameter int POS_W  = 4
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [POS_W-1:0] digit;
  logic             load;
  logic [CH_W-1:0]  ch_sel;

  modport master (output digit, load, ch_sel);
  modport slave  (input  digit, load, ch_sel);
endinterface

// File: rtl/stepper_channel.sv
// One stepper channel: command FIFO, move/hold sequencer, position and phase tracking.
//   state | meaning
//   IDLE  | coils off, waiting for a queued target
//   MOVE  | stepping toward target on each step tick
//   HOLD  | at target, coils energised until HOLD_TICKS ticks pass
module stepper_channel
  import stepper_pkg::*;
#(
  parameter int POS_W          = 4,
  parameter int STEPS_PER_UNIT = 50,
  parameter int FIFO_DEPTH     = 4,
  parameter int HOLD_TICKS     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             load,
  input  logic [POS_W-1:0] digit,
  input  logic             half,
  output logic [3:0]       coils,
  output logic             busy,
  output logic             fifo_full,
  output logic             overflow
);

  localparam int PW = $clog2((2 ** POS_W) * STEPS_PER_UNIT * 2) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [PW-1:0] HS_PER_UNIT = PW'(STEPS_PER_UNIT * 2);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_TICKS - 1);

  logic [POS_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             empty, full, push, pop;
  logic [POS_W-1:0] head;

  state_t        state, state_n;
  logic [PW-1:0] pos, pos_n, target, target_n, step_hs;
  logic [2:0]    idx, idx_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic          dir, fine;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push      = load && (!full || pop);
  assign head      = mem[rd_ptr[AW-1:0]];
  assign fifo_full = full;
  assign busy      = (state != IDLE) || !empty;

  // An odd position in full-step mode takes one half-step to get back on even phases.
  assign dir     = (target > pos);
  assign fine    = half || pos[0];
  assign step_hs = fine ? PW'(1) : PW'(2);

  always_comb begin
    state_n  = state;
    pos_n    = pos;
    idx_n    = idx;
    target_n = target;
    hold_n   = hold_cnt;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          target_n = PW'(head) * HS_PER_UNIT;
          state_n  = MOVE;
        end
      end
      MOVE: begin
        if (pos == target) begin
          state_n = HOLD;
          hold_n  = '0;
        end else if (tick) begin
          idx_n = phase_next(idx, dir, fine);
          pos_n = dir ? pos + step_hs : pos - step_hs;
        end
      end
      HOLD: begin
        if (!empty) begin
          pop      = 1'b1;
          target_n = PW'(head) * HS_PER_UNIT;
          state_n  = MOVE;
        end else if (tick) begin
          if (hold_cnt == HOLD_LAST) state_n = IDLE;
          else                       hold_n  = hold_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= digit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pos      <= '0;
      idx      <= '0;
      target   <= '0;
      hold_cnt <= '0;
      coils    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      pos      <= pos_n;
      idx      <= idx_n;
      target   <= target_n;
      hold_cnt <= hold_n;
      coils    <= (state_n == IDLE) ? 4'b0000 : PHASE_TABLE[idx_n];
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (load && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/stepper_array_ctrl.sv
// Array of bipolar stepper channels fed from one digit/load bus with a shared step-tick divider.
module stepper_array_ctrl
  import stepper_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int POS_W          = 4,
  parameter int STEPS_PER_UNIT = 50,
  parameter int FIFO_DEPTH     = 4,
  parameter int DIV_W          = 20,
  parameter int STEP_DIV       = 100000,
  parameter int HOLD_TICKS     = 8
) (
  input  logic              clk,
  input  logic              reset,
  stepper_array_ctrl_if.slave cmd,
  input  logic [NUM_CH-1:0] half_step,
  output logic [NUM_CH-1:0] A1,
  output logic [NUM_CH-1:0] A2,
  output logic [NUM_CH-1:0] B1,
  output logic [NUM_CH-1:0] B2,
  output logic [NUM_CH-1:0] PWM1,
  output logic [NUM_CH-1:0] PWM2,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] fifo_full,
  output logic [NUM_CH-1:0] overflow
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

  logic [DIV_W-1:0] div;
  logic             tick;

  assign tick = (div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset)     div <= '0;
    else if (tick) div <= '0;
    else           div <= div + 1'b1;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic       sel;
    logic [3:0] coils;

    // Out-of-range ch_sel matches no channel, so the load is simply dropped.
    assign sel = cmd.load && (cmd.ch_sel == CH_W'(i));

    stepper_channel #(
      .POS_W          (POS_W),
      .STEPS_PER_UNIT (STEPS_PER_UNIT),
      .FIFO_DEPTH     (FIFO_DEPTH),
      .HOLD_TICKS     (HOLD_TICKS)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .load      (sel),
      .digit     (cmd.digit),
      .half      (half_step[i]),
      .coils     (coils),
      .busy      (busy[i]),
      .fifo_full (fifo_full[i]),
      .overflow  (overflow[i])
    );

    assign A1[i]   = coils[3];
    assign B1[i]   = coils[2];
    assign A2[i]   = coils[1];
    assign B2[i]   = coils[0];
    assign PWM1[i] = coils[3] | coils[1];
    assign PWM2[i] = coils[2] | coils[0];
  end

endmodule

// File: tb/tb_stepper_array_ctrl.sv
// Directed bench for stepper_array_ctrl with a short step divider and small steps-per-unit.
module tb_stepper_array_ctrl;

  localparam int NUM_CH   = 2;
  localparam int POS_W    = 4;
  localparam int SPU      = 2;
  localparam int DEPTH    = 4;
  localparam int STEP_DIV = 4;
  localparam int HOLD     = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NUM_CH-1:0] half_step;
  logic [NUM_CH-1:0] A1, A2, B1, B2, PWM1, PWM2, busy, fifo_full, overflow;
  int checks = 0;
  int errors = 0;
  int tb_div = 0;
  logic tick_m;

  stepper_array_ctrl_if #(.NUM_CH(NUM_CH), .POS_W(POS_W)) cmd_if ();

  stepper_array_ctrl #(
    .NUM_CH(NUM_CH), .POS_W(POS_W), .STEPS_PER_UNIT(SPU), .FIFO_DEPTH(DEPTH),
    .DIV_W(20), .STEP_DIV(STEP_DIV), .HOLD_TICKS(HOLD)
  ) dut (
    .clk(clk), .reset(reset), .cmd(cmd_if), .half_step(half_step),
    .A1(A1), .A2(A2), .B1(B1), .B2(B2), .PWM1(PWM1), .PWM2(PWM2),
    .busy(busy), .fifo_full(fifo_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset)                      tb_div <= 0;
    else if (tb_div == STEP_DIV-1)  tb_div <= 0;
    else                            tb_div <= tb_div + 1;
  end
  assign tick_m = (tb_div == STEP_DIV-1);

  function automatic logic [3:0] coils(input int ch);
    return {A1[ch], B1[ch], A2[ch], B2[ch]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until just after the edge that consumes the next step tick.
  task automatic tick_wait();
    int g;
    g = 0;
    while (!tick_m && g < 2*STEP_DIV) begin
      step();
      g++;
    end
    if (!tick_m) begin
      errors++;
      $display("FAIL tick_wait: no tick after %0d cycles, required within %0d", g, 2*STEP_DIV);
    end
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    checks++;
    if ({A1, A2, B1, B2, PWM1, PWM2, busy, fifo_full, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required all zero",
               {A1, A2, B1, B2, PWM1, PWM2, busy, fifo_full, overflow});
    end
    reset = 1'b0;
  endtask

  task automatic test_single_full();
    int n, g;
    logic t;
    half_step = 2'b00;
    cmd_if.digit = 4'd1; cmd_if.ch_sel = 1'b0; cmd_if.load = 1'b1;
    step();
    cmd_if.load = 1'b0;
    step();
    checks++;
    if (coils(0) !== 4'b1000 || PWM1[0] !== 1'b1 || PWM2[0] !== 1'b0 || busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL t1_energise: coils=%b pwm=%b%b busy=%b, required 1000 10 1",
               coils(0), PWM1[0], PWM2[0], busy[0]);
    end
    tick_wait();
    checks++;
    if (coils(0) !== 4'b0100 || PWM1[0] !== 1'b0 || PWM2[0] !== 1'b1) begin
      errors++;
      $display("FAIL t1_step1: coils=%b pwm=%b%b, required 0100 01", coils(0), PWM1[0], PWM2[0]);
    end
    tick_wait();
    checks++;
    if (coils(0) !== 4'b0010 || dut.g_ch[0].u_ch.pos !== 4) begin
      errors++;
      $display("FAIL t1_step2: coils=%b pos=%0d, required 0010 pos 4", coils(0), dut.g_ch[0].u_ch.pos);
    end
    n = 0; g = 0;
    while (n < HOLD && g < 400) begin
      t = tick_m; step(); g++;
      if (t) n++;
      checks++;
      if (n < HOLD) begin
        if (coils(0) !== 4'b0010 || busy[0] !== 1'b1 || PWM1[0] !== 1'b1) begin
          errors++;
          $display("FAIL t1_hold: tick %0d coils=%b busy=%b pwm1=%b, required 0010 1 1",
                   n, coils(0), busy[0], PWM1[0]);
        end
      end else if (coils(0) !== 4'b0000 || busy[0] !== 1'b0 || PWM1[0] !== 1'b0) begin
        errors++;
        $display("FAIL t1_release: coils=%b busy=%b pwm1=%b, required 0000 0 0", coils(0), busy[0], PWM1[0]);
      end
    end
    if (n < HOLD) begin
      errors++;
      $display("FAIL t1_hold_timeout: %0d ticks seen, required %0d", n, HOLD);
    end
  endtask

  task automatic test_half_step();
    logic [3:0] exp [4];
    int n, g;
    logic t;
    exp = '{4'b1100, 4'b0100, 4'b0110, 4'b0010};
    half_step = 2'b10;
    cmd_if.digit = 4'd1; cmd_if.ch_sel = 1'b1; cmd_if.load = 1'b1;
    step();
    cmd_if.load = 1'b0;
    step();
    checks++;
    if (coils(1) !== 4'b1000) begin
      errors++;
      $display("FAIL t2_energise: coils=%b, required 1000", coils(1));
    end
    for (int i = 0; i < 4; i++) begin
      tick_wait();
      checks++;
      if (coils(1) !== exp[i] || coils(0) !== 4'b0000 || busy[0] !== 1'b0) begin
        errors++;
        $display("FAIL t2_phase%0d: ch1=%b ch0=%b busy0=%b, required ch1=%b ch0=0000 busy0=0",
                 i, coils(1), coils(0), busy[0], exp[i]);
      end
    end
    checks++;
    if (dut.g_ch[1].u_ch.pos !== 4) begin
      errors++;
      $display("FAIL t2_pos: pos=%0d, required 4", dut.g_ch[1].u_ch.pos);
    end
    n = 0; g = 0;
    while (n < HOLD && g < 400) begin
      t = tick_m; step(); g++;
      if (t) n++;
      checks++;
      if (n < HOLD) begin
        if (coils(1) !== 4'b0010 || busy[1] !== 1'b1 || busy[0] !== 1'b0) begin
          errors++;
          $display("FAIL t2_hold: coils=%b busy=%b, required 0010 busy=10", coils(1), busy);
        end
      end else if (coils(1) !== 4'b0000 || busy[1] !== 1'b0) begin
        errors++;
        $display("FAIL t2_release: coils=%b busy=%b, required 0000 0", coils(1), busy[1]);
      end
    end
    if (n < HOLD) begin
      errors++;
      $display("FAIL t2_hold_timeout: %0d ticks seen, required %0d", n, HOLD);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp [6];
    int k, n, g;
    logic t;
    exp = '{4'b0001, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    cmd_if.ch_sel = 1'b0;
    cmd_if.digit = 4'd2; cmd_if.load = 1'b1;
    step();
    cmd_if.digit = 4'd0;
    step();
    cmd_if.load = 1'b0;
    k = 0; g = 0;
    while (k < 6 && g < 200) begin
      t = tick_m; step(); g++;
      checks++;
      if ((PWM1[0] | PWM2[0]) !== 1'b1 || busy[0] !== 1'b1) begin
        errors++;
        $display("FAIL t3_drive: pwm=%b%b busy=%b, required drive on and busy", PWM1[0], PWM2[0], busy[0]);
      end
      if (t) begin
        checks++;
        if (coils(0) !== exp[k]) begin
          errors++;
          $display("FAIL t3_phase%0d: coils=%b, required %b", k, coils(0), exp[k]);
        end
        k++;
      end
    end
    checks++;
    if (k < 6 || dut.g_ch[0].u_ch.pos !== 0) begin
      errors++;
      $display("FAIL t3_end: steps=%0d pos=%0d, required 6 steps pos 0", k, dut.g_ch[0].u_ch.pos);
    end
    n = 0; g = 0;
    while (n < HOLD && g < 400) begin
      t = tick_m; step(); g++;
      if (t) n++;
      checks++;
      if (n < HOLD) begin
        if (coils(0) !== 4'b1000 || busy[0] !== 1'b1) begin
          errors++;
          $display("FAIL t3_hold: coils=%b busy=%b, required 1000 1", coils(0), busy[0]);
        end
      end else if (coils(0) !== 4'b0000 || busy[0] !== 1'b0) begin
        errors++;
        $display("FAIL t3_release: coils=%b busy=%b, required 0000 0", coils(0), busy[0]);
      end
    end
  endtask

  task automatic test_overflow();
    int g;
    cmd_if.ch_sel = 1'b0;
    cmd_if.digit = 4'd7; cmd_if.load = 1'b1;
    step();
    cmd_if.load = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      cmd_if.digit = 4'(i + 1); cmd_if.load = 1'b1;
      step();
      checks++;
      if (fifo_full[0] !== (i >= 3) || overflow[0] !== (i == 4)) begin
        errors++;
        $display("FAIL t4_load%0d: full=%b ovf=%b, required full=%b ovf=%b",
                 i, fifo_full[0], overflow[0], (i >= 3), (i == 4));
      end
    end
    cmd_if.load = 1'b0;
    g = 0;
    while (busy[0] && g < 3000) begin
      step(); g++;
    end
    checks++;
    if (busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL t4_timeout: busy=%b after %0d cycles, required 0", busy[0], g);
    end
    checks++;
    if (dut.g_ch[0].u_ch.pos !== 16 || overflow[0] !== 1'b1 || fifo_full[0] !== 1'b0 || coils(0) !== 4'b0000) begin
      errors++;
      $display("FAIL t4_final: pos=%0d ovf=%b full=%b coils=%b, required pos 16 ovf 1 full 0 coils 0000",
               dut.g_ch[0].u_ch.pos, overflow[0], fifo_full[0], coils(0));
    end
  endtask

  task automatic test_reset_mid_move();
    cmd_if.ch_sel = 1'b0;
    cmd_if.digit = 4'd9; cmd_if.load = 1'b1;
    step();
    cmd_if.load = 1'b0;
    step();
    cmd_if.digit = 4'd3; cmd_if.load = 1'b1;
    step();
    cmd_if.load = 1'b0;
    tick_wait();
    tick_wait();
    checks++;
    if (coils(0) !== 4'b0010 || busy[0] !== 1'b1 || dut.g_ch[0].u_ch.pos !== 20) begin
      errors++;
      $display("FAIL t5_premove: coils=%b busy=%b pos=%0d, required 0010 1 pos 20",
               coils(0), busy[0], dut.g_ch[0].u_ch.pos);
    end
    reset = 1'b1;
    step();
    checks++;
    if ({A1, A2, B1, B2, PWM1, PWM2, busy, fifo_full, overflow} !== '0 || dut.g_ch[0].u_ch.pos !== 0) begin
      errors++;
      $display("FAIL t5_reset: outs=%b pos=%0d, required all zero pos 0",
               {A1, A2, B1, B2, PWM1, PWM2, busy, fifo_full, overflow}, dut.g_ch[0].u_ch.pos);
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (busy !== 2'b00 || coils(0) !== 4'b0000) begin
        errors++;
        $display("FAIL t5_quiet%0d: busy=%b coils=%b, required 00 0000", i, busy, coils(0));
      end
    end
  endtask

  task automatic test_same_position();
    int n, g;
    logic t;
    half_step = 2'b00;
    cmd_if.ch_sel = 1'b0;
    cmd_if.digit = 4'd0; cmd_if.load = 1'b1;
    step();
    cmd_if.load = 1'b0;
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL t6_busy_queued: busy=%b, required 1", busy[0]);
    end
    step();
    checks++;
    if (coils(0) !== 4'b1000 || PWM1[0] !== 1'b1 || busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL t6_energise: coils=%b pwm1=%b busy=%b, required 1000 1 1", coils(0), PWM1[0], busy[0]);
    end
    n = 0; g = 0;
    while (n < HOLD && g < 400) begin
      t = tick_m; step(); g++;
      if (t) n++;
      checks++;
      if (n < HOLD) begin
        if (coils(0) !== 4'b1000 || busy[0] !== 1'b1) begin
          errors++;
          $display("FAIL t6_hold: tick %0d coils=%b busy=%b, required 1000 1", n, coils(0), busy[0]);
        end
      end else if (coils(0) !== 4'b0000 || busy[0] !== 1'b0 || dut.g_ch[0].u_ch.pos !== 0) begin
        errors++;
        $display("FAIL t6_release: coils=%b busy=%b pos=%0d, required 0000 0 pos 0",
                 coils(0), busy[0], dut.g_ch[0].u_ch.pos);
      end
    end
    if (n < HOLD) begin
      errors++;
      $display("FAIL t6_hold_timeout: %0d ticks seen, required %0d", n, HOLD);
    end
  endtask

  initial begin
    half_step     = 2'b00;
    cmd_if.digit  = '0;
    cmd_if.load   = 1'b0;
    cmd_if.ch_sel = '0;
    test_reset();
    test_single_full();
    test_half_step();
    test_back_to_back();
    test_overflow();
    test_reset_mid_move();
    test_same_position();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
